// File: rtl/count_seq_ctrl.sv
// Sequencing controller for an up-counter: clears it, enables it up to a latched
// terminal value, then stops (one-shot) or clears and restarts (continuous).
module count_seq_ctrl #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned RUNS_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              mode,
  input  logic [WIDTH-1:0]  term,
  input  logic [WIDTH-1:0]  count_in,
  output logic              cnt_clr,
  output logic              cnt_en,
  output logic              busy,
  output logic              tc_pulse,
  output logic [RUNS_W-1:0] runs
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLR  = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_term;
  logic               r_mode;
  logic               r_tc;
  logic [RUNS_W-1:0]  r_runs;
  logic               w_hit;

  // >= also catches a counter that was found already past the terminal value
  assign w_hit = (r_state == S_RUN) && (count_in >= r_term);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_term  <= '0;
      r_mode  <= 1'b0;
      r_tc    <= 1'b0;
      r_runs  <= '0;
    end else begin
      r_tc <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_term  <= term;
            r_mode  <= mode;
            r_runs  <= '0;
            r_state <= S_CLR;
          end
        end
        S_CLR: begin
          r_state <= stop ? S_IDLE : S_RUN;
        end
        S_RUN: begin
          if (stop) begin
            r_state <= S_IDLE;
          end else if (w_hit) begin
            r_tc <= 1'b1;
            if (r_runs != {RUNS_W{1'b1}}) r_runs <= r_runs + RUNS_W'(1);
            r_state <= r_mode ? S_CLR : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Counter controls decode straight from state so reset drops them immediately
  assign cnt_clr  = (r_state == S_CLR);
  assign cnt_en   = (r_state == S_RUN) && !w_hit && !stop;
  assign busy     = (r_state != S_IDLE);
  assign tc_pulse = r_tc;
  assign runs     = r_runs;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Randomized bench for count_seq_ctrl: hit schedule predicted arithmetically,
// pulses checked by a scoreboard monitor, counter modelled as the environment.
module tb_count_seq_ctrl;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned RUNS_W = 8;
  localparam int unsigned NONE   = 100000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              mode = 1'b0;
  logic [WIDTH-1:0]  term = '0;
  logic [WIDTH-1:0]  cnt = '0;
  logic              cnt_clr;
  logic              cnt_en;
  logic              busy;
  logic              tc_pulse;
  logic [RUNS_W-1:0] runs;

  typedef struct {
    int unsigned cyc;
    int unsigned runs;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  count_seq_ctrl #(.WIDTH(WIDTH), .RUNS_W(RUNS_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .term     (term),
    .count_in (cnt),
    .cnt_clr  (cnt_clr),
    .cnt_en   (cnt_en),
    .busy     (busy),
    .tc_pulse (tc_pulse),
    .runs     (runs)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Counter being controlled; it has no reset of its own
  always @(posedge clk) begin
    if (cnt_clr)     cnt <= '0;
    else if (cnt_en) cnt <= cnt + 4'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: every tc_pulse must match the oldest predicted hit
  always @(negedge clk) begin
    if (!rst) begin
      while (q.size() != 0 && q[0].cyc < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL tc_missing: no pulse at cyc %0d (now %0d)", q[0].cyc, cyc);
        void'(q.pop_front());
      end
      if (tc_pulse) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL tc_unexpected: pulse at cyc %0d, none predicted", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("tc_cyc", cyc, e.cyc);
          chk("tc_runs", 32'(runs), e.runs);
        end
      end
    end
  end

  // One sequence: start with (m,t); stop high in the cycle before edge a+s_off
  task automatic run_seq(input logic m, input int unsigned t, input int unsigned s_off);
    int unsigned a, s, e_end, per, nh, c, ph, k;
    @(negedge clk);
    start = 1'b1; mode = m; term = WIDTH'(t);
    @(negedge clk);
    a = cyc;
    start = 1'b0;
    mode  = ~m;
    term  = WIDTH'($urandom_range(0, 15));
    per = t + 2;
    s   = a + s_off;
    nh  = 0;
    if (m) begin
      e_end = s;
      k = 1;
      while (a + k * per < s) begin
        q.push_back('{cyc: a + k * per, runs: (k > 255) ? 255 : k});
        nh = (k > 255) ? 255 : k;
        k++;
      end
    end else begin
      e_end = (a + per < s) ? a + per : s;
      if (a + per < s) begin
        q.push_back('{cyc: a + per, runs: 1});
        nh = 1;
      end
    end
    c = a;
    forever begin
      if (c == s - 1) stop = 1'b1;
      if (c == s)     stop = 1'b0;
      if (c == a + 1 && e_end > a + 2) begin
        start = 1'b1;
        term  = WIDTH'($urandom_range(0, 15));
      end else if (c == a + 2) begin
        start = 1'b0;
      end
      #1;
      if (c == a) begin
        chk("clr_first", 32'(cnt_clr), 1);
        chk("busy_first", 32'(busy), 1);
      end else if (c < e_end) begin
        ph = (c - a - 1) % per;
        chk("busy_run", 32'(busy), 1);
        chk("count", 32'(cnt), (ph <= t) ? ph : t);
        chk("cnt_clr", 32'(cnt_clr), (ph == t + 1) ? 1 : 0);
        chk("cnt_en", 32'(cnt_en), (c == s - 1) ? 0 : ((ph < t) ? 1 : 0));
      end
      if (c == e_end) begin
        chk("busy_end", 32'(busy), 0);
        chk("en_end", 32'(cnt_en), 0);
        chk("clr_end", 32'(cnt_clr), 0);
        chk("runs_end", 32'(runs), nh);
        if (!m && a + per < s) chk("oneshot_hold", 32'(cnt), t);
        break;
      end
      @(negedge clk);
      c = cyc;
    end
  endtask

  initial begin
    int unsigned a, hold, t, so;
    logic m;
    start = 1'b1; mode = 1'b1; term = 4'd3;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_clr", 32'(cnt_clr), 0);
    chk("rst_en", 32'(cnt_en), 0);
    chk("rst_tc", 32'(tc_pulse), 0);
    chk("rst_runs", 32'(runs), 0);
    start = 1'b0;
    rst   = 1'b0;

    run_seq(1'b0, 5, NONE);       // one-shot, term 5
    run_seq(1'b1, 3, 21);         // continuous, term 3, then stop
    run_seq(1'b1, 2, 4);          // stop lands on the first hit cycle
    chk("hitstop_runs", 32'(runs), 0);
    run_seq(1'b1, 0, 13);         // term 0: pulse every 2 cycles, no enable
    run_seq(1'b0, 15, NONE);      // term 15 reaches max without wrap
    repeat (3) @(negedge clk);
    chk("max_hold", 32'(cnt), 15);
    run_seq(1'b1, 0, 601);        // 300 hits saturate runs at 255

    for (int i = 0; i < 25; i++) begin
      m  = 1'($urandom_range(0, 1));
      t  = $urandom_range(0, 15);
      if (m) so = $urandom_range(1, 4 * (t + 2));
      else   so = ($urandom_range(0, 1) != 0) ? NONE : $urandom_range(1, t + 3);
      run_seq(m, t, so);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Async reset in the middle of a continuous run
    @(negedge clk);
    start = 1'b1; mode = 1'b1; term = 4'd7;
    @(negedge clk);
    a = cyc;
    start = 1'b0;
    while (cyc < a + 5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_en", 32'(cnt_en), 0);
    chk("arst_clr", 32'(cnt_clr), 0);
    chk("arst_runs", 32'(runs), 0);
    chk("arst_cnt", 32'(cnt), 4);
    hold = 32'(cnt);
    repeat (3) @(negedge clk);
    chk("arst_frozen", 32'(cnt), hold);
    rst = 1'b0;
    run_seq(1'b0, 1, NONE);

    repeat (4) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: %0d predicted pulses left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
